// File: rtl/pipe_ctrl_seq.sv
// pipe_ctrl_seq: central stall/flush sequencer for a 6-stage pipeline
// (PC, IF, ID, EX, MEM, WB).
//
// Merges per-stage stall requests into one stall vector, where stall[n]=1
// means Stop. The vector is combinational from the requests and the FSM
// state. On a committed exception or ERET the block runs a flush of
// FLUSH_CYCLES cycles and redirects the PC. It also keeps debug counters
// for stalled cycles and for pathological stall lengths.
//
// Ports
//   clk            in   1   clock; all state updates on the rising edge
//   rst            in   1   synchronous reset, active-high
//   stallreq_if    in   1   instruction bus wait
//   stallreq_id    in   1   load-use hazard in ID
//   stallreq_ex    in   1   multi-cycle operation busy in EX
//   stallreq_mem   in   1   data bus wait in MEM
//   excp_valid     in   1   exception/ERET committed in MEM (single-cycle pulse)
//   excp_type      in   32  exception code, qualified by excp_valid
//   cp0_epc        in   32  EPC value, sampled together with excp_valid
//   cnt_clr        in   1   synchronous clear of stall_cycles
//   stall          out  6   bit0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB, 5 WB
//   flush          out  1   clear all pipeline registers and load new_pc
//   new_pc         out  32  redirect target; holds its value until the next exception
//   stall_cycles   out  32  number of RUN cycles with a non-zero stall vector
//   stall_timeout  out  1   sticky flag: stall held for STALL_LIMIT consecutive cycles
module pipe_ctrl_seq #(
    parameter int          FLUSH_CYCLES = 1,
    parameter int          STALL_LIMIT  = 1024,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
    parameter logic [31:0] ERET_TYPE    = 32'h0000_000e
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        excp_valid,
    input  logic [31:0] excp_type,
    input  logic [31:0] cp0_epc,
    input  logic        cnt_clr,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic [31:0] stall_cycles,
    output logic        stall_timeout
);

    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int RW = $clog2(STALL_LIMIT + 1);
    localparam logic [FW-1:0] FCNT_LOAD = FW'(FLUSH_CYCLES - 1);
    localparam logic [RW-1:0] RUN_MAX   = RW'(STALL_LIMIT);
    localparam logic [RW-1:0] RUN_LAST  = RW'(STALL_LIMIT - 1);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t         state_r;
    state_t         next_state_s;
    logic [FW-1:0]  fcnt_r;
    logic [FW-1:0]  fcnt_next_s;
    logic           take_excp_s;
    logic [5:0]     stall_s;
    logic           stall_any_s;
    logic [31:0]    new_pc_r;
    logic [31:0]    stall_cycles_r;
    logic [RW-1:0]  run_len_r;
    logic           stall_timeout_r;

    // Merge stall requests: the deepest requester stops itself and every
    // stage upstream of it. A flush overrides all requests.
    always_comb begin
        stall_s = 6'b000000;
        if (state_r == ST_FLUSH) begin
            stall_s = 6'b000000;
        end else if (stallreq_mem) begin
            stall_s = 6'b011111;
        end else if (stallreq_ex) begin
            stall_s = 6'b001111;
        end else if (stallreq_id) begin
            stall_s = 6'b000111;
        end else if (stallreq_if) begin
            stall_s = 6'b000011;
        end else begin
            stall_s = 6'b000000;
        end
    end

    assign stall_any_s = (stall_s != 6'b000000);

    // Next-state logic. An exception that arrives while MEM is stalled is
    // not taken; its source keeps the pulse until MEM is released.
    always_comb begin
        next_state_s = state_r;
        fcnt_next_s  = fcnt_r;
        take_excp_s  = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (excp_valid && !stallreq_mem) begin
                    take_excp_s  = 1'b1;
                    next_state_s = ST_FLUSH;
                    fcnt_next_s  = FCNT_LOAD;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (fcnt_r == {FW{1'b0}}) begin
                    next_state_s = ST_RUN;
                end else begin
                    fcnt_next_s = fcnt_r - FW'(1);
                end
            end
            default: begin
                next_state_s = ST_RUN;
                fcnt_next_s  = {FW{1'b0}};
            end
        endcase
    end

    // FSM state and flush-length counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
            fcnt_r  <= {FW{1'b0}};
        end else begin
            state_r <= next_state_s;
            fcnt_r  <= fcnt_next_s;
        end
    end

    // Redirect target. It is latched when the exception is taken and then
    // held, so it stays stable after flush drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            new_pc_r <= 32'h0000_0000;
        end else if (take_excp_s) begin
            new_pc_r <= (excp_type == ERET_TYPE) ? cp0_epc : EXC_VECTOR;
        end else begin
            new_pc_r <= new_pc_r;
        end
    end

    // Stalled-cycle counter. A clear takes priority over an increment, and
    // the counter wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_r <= 32'h0000_0000;
        end else if (cnt_clr) begin
            stall_cycles_r <= 32'h0000_0000;
        end else if ((state_r == ST_RUN) && stall_any_s) begin
            stall_cycles_r <= stall_cycles_r + 32'd1;
        end else begin
            stall_cycles_r <= stall_cycles_r;
        end
    end

    // Consecutive-stall run length. It saturates at STALL_LIMIT. The timeout
    // flag is set on the edge where the run reaches the limit and only reset
    // clears it again.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_len_r       <= {RW{1'b0}};
            stall_timeout_r <= 1'b0;
        end else if (!stall_any_s) begin
            run_len_r       <= {RW{1'b0}};
            stall_timeout_r <= stall_timeout_r;
        end else begin
            if (run_len_r < RUN_MAX) begin
                run_len_r <= run_len_r + RW'(1);
            end else begin
                run_len_r <= run_len_r;
            end
            stall_timeout_r <= stall_timeout_r | (run_len_r >= RUN_LAST);
        end
    end

    assign stall         = stall_s;
    assign flush         = (state_r == ST_FLUSH);
    assign new_pc        = new_pc_r;
    assign stall_cycles  = stall_cycles_r;
    assign stall_timeout = stall_timeout_r;

endmodule

// File: tb/tb_pipe_ctrl_seq.sv
// Testbench for pipe_ctrl_seq. It uses FLUSH_CYCLES=3 and STALL_LIMIT=16.
// The stimulus process runs a reference model and pushes the expected
// outputs for every cycle into a queue. A separate monitor process samples
// the DUT on the falling edge, pops the queue and compares.
module tb_pipe_ctrl_seq;

    localparam int          FC    = 3;
    localparam int          LIMIT = 16;
    localparam logic [31:0] VEC   = 32'h0000_0020;
    localparam logic [31:0] ERET  = 32'h0000_000e;

    logic        clk;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic        excp_valid;
    logic [31:0] excp_type, cp0_epc;
    logic        cnt_clr;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc, stall_cycles;
    logic        stall_timeout;

    pipe_ctrl_seq #(
        .FLUSH_CYCLES (FC),
        .STALL_LIMIT  (LIMIT),
        .EXC_VECTOR   (VEC),
        .ERET_TYPE    (ERET)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stallreq_if   (stallreq_if),
        .stallreq_id   (stallreq_id),
        .stallreq_ex   (stallreq_ex),
        .stallreq_mem  (stallreq_mem),
        .excp_valid    (excp_valid),
        .excp_type     (excp_type),
        .cp0_epc       (cp0_epc),
        .cnt_clr       (cnt_clr),
        .stall         (stall),
        .flush         (flush),
        .new_pc        (new_pc),
        .stall_cycles  (stall_cycles),
        .stall_timeout (stall_timeout)
    );

    // The clock starts high, so the first falling edge comes before the
    // first rising edge.
    initial clk = 1'b1;
    always #5 clk = ~clk;

    typedef struct {
        bit          known;
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic [31:0] cnt;
        logic        to;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state
    bit          m_known = 1'b0;
    int          m_flush_left = 0;   // remaining flush cycles; 0 = running
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_cnt = 32'h0;
    int          m_run = 0;
    bit          m_to = 1'b0;

    // The deepest stalled stage stops itself and every upstream stage.
    function automatic logic [5:0] model_stall();
        int n;
        if (m_flush_left > 0) return 6'b000000;
        n = stallreq_mem ? 5 : stallreq_ex ? 4 : stallreq_id ? 3 : stallreq_if ? 2 : 0;
        return 6'((1 << n) - 1);
    endfunction

    function automatic exp_t model_expect();
        exp_t e;
        e.known = m_known;
        e.stall = model_stall();
        e.flush = (m_flush_left > 0);
        e.pc    = m_pc;
        e.cnt   = m_cnt;
        e.to    = m_to;
        return e;
    endfunction

    task automatic model_update();
        logic [5:0] s;
        s = model_stall();
        if (rst) begin
            m_known = 1'b1; m_flush_left = 0; m_pc = 32'h0;
            m_cnt = 32'h0; m_run = 0; m_to = 1'b0;
        end else if (m_known) begin
            if (cnt_clr) m_cnt = 32'h0;
            else if (s != 6'b0) m_cnt = m_cnt + 32'd1;
            if (s != 6'b0) begin
                m_run = (m_run + 1 > LIMIT) ? LIMIT : m_run + 1;
                if (m_run == LIMIT) m_to = 1'b1;
            end else begin
                m_run = 0;
            end
            if (m_flush_left > 0) begin
                m_flush_left = m_flush_left - 1;
            end else if (excp_valid && !stallreq_mem) begin
                m_flush_left = FC;
                m_pc = (excp_type == ERET) ? cp0_epc : VEC;
            end
        end
    endtask

    // Pushes the expectation for the current cycle, then advances to the
    // next cycle. The inputs change 1 time unit after the rising edge.
    task automatic step();
        q.push_back(model_expect());
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input bit r, input bit i_if, input bit i_id, input bit i_ex,
                         input bit i_mem, input bit ev, input logic [31:0] et,
                         input logic [31:0] epc, input bit clr);
        rst = r; stallreq_if = i_if; stallreq_id = i_id; stallreq_ex = i_ex;
        stallreq_mem = i_mem; excp_valid = ev; excp_type = et; cp0_epc = epc;
        cnt_clr = clr;
        step();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compares the DUT outputs against the queued expectation once
    // per cycle, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.known) begin
                chk("stall",         {26'h0, stall},         {26'h0, e.stall});
                chk("flush",         {31'h0, flush},         {31'h0, e.flush});
                chk("new_pc",        new_pc,                 e.pc);
                chk("stall_cycles",  stall_cycles,           e.cnt);
                chk("stall_timeout", {31'h0, stall_timeout}, {31'h0, e.to});
            end
        end
    end

    initial begin
        int r;
        int wait_cnt;
        // reset, then quiet
        drive(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0);
        drive(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0);
        idle(2);
        // stall priority patterns
        drive(0, 0, 1, 0, 1, 0, 32'h0, 32'h0, 0);
        drive(0, 0, 1, 0, 0, 0, 32'h0, 32'h0, 0);
        drive(0, 1, 0, 0, 0, 0, 32'h0, 32'h0, 0);
        drive(0, 1, 1, 1, 0, 0, 32'h0, 32'h0, 0);
        idle(1);
        // exception while EX keeps stalling; stall is forced to 0 during flush
        drive(0, 0, 0, 1, 0, 1, 32'h8, 32'h0, 0);
        for (int k = 0; k < 5; k++) drive(0, 0, 0, 1, 0, 0, 32'h0, 32'h0, 0);
        idle(1);
        // ERET redirects to the EPC
        drive(0, 0, 0, 0, 0, 1, ERET, 32'h1000_0040, 0);
        idle(5);
        // exception held while MEM is stalled, then retried with MEM free
        for (int k = 0; k < 3; k++) drive(0, 0, 0, 0, 1, 1, 32'h8, 32'h0, 0);
        drive(0, 0, 0, 0, 0, 1, 32'h8, 32'h0, 0);
        idle(4);
        // long EX stall reaches the timeout; clear the counter during the stall
        for (int k = 0; k < 20; k++) drive(0, 0, 0, 1, 0, 0, 32'h0, 32'h0, (k == 10));
        idle(3);
        // reset in the second flush cycle
        drive(0, 0, 0, 0, 0, 1, 32'h8, 32'h0, 0);
        drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0);
        drive(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0);
        idle(3);
        // randomized traffic
        for (int k = 0; k < 800; k++) begin
            logic [31:0] et;
            r  = $urandom_range(0, 2);
            et = (r == 0) ? 32'h8 : (r == 1) ? ERET : $urandom;
            drive(($urandom_range(0, 99) < 1), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 11) == 0),
                  et, $urandom, ($urandom_range(0, 29) == 0));
        end
        idle(2);
        // let the monitor drain the queue, with a bounded wait
        wait_cnt = 0;
        while (q.size() > 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: actual=%0d pending required=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
